r820_freq_gate: RTL and testbench

Upstream feeder for the R820 I2C control stage. It accepts frequency and run commands from the host command decoder and presents a stable `freq`/`run` pair to the tuner controller. It rate-limits reprogramming so the controller always finishes an I2C sequence before the next change. Band crossings at the VHF threshold get a longer hold-off, because the controller then rewrites all 32 init registers.

---
 rtl/r820_pkg.sv | 24 ++
 rtl/r820_holdoff_timer.sv | 29 ++
 rtl/r820_freq_gate.sv | 150 +++++++++++++++
 tb/tb_r820_freq_gate.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/r820_pkg.sv
// Shared constants, state encoding and band helper for the R820 tuner control path.
// Also the home of the VHF threshold the R820 controller's vhf_on decision should use.
package r820_pkg;

    localparam int unsigned VHF_THR_DEF          = 585;
    localparam int unsigned IF_FREQ              = 4_000_000;
    localparam logic [31:0] F_MIN                = 32'd24_000_000;
    localparam logic [31:0] F_MAX                = 32'd1_766_000_000;
    localparam int unsigned HOLD_CYCLES_DEF      = 4096;
    localparam int unsigned BAND_HOLD_CYCLES_DEF = 65536;
    localparam int unsigned CNT_W_DEF            = 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // VHF only counts while running; a stopped tuner sits in no band.
    function automatic logic is_vhf(input logic [31:0] f, input logic r, input logic [15:0] thr);
        return (f[31:16] > thr) && r;
    endfunction

endpackage

// File: rtl/r820_holdoff_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module r820_holdoff_timer
    import r820_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/r820_freq_gate.sv
// Rate-limited freq/run feeder for the R820 I2C controller; band crossings get a long hold.
// Build option FREQ_CLAMP_EN clamps captured frequencies to [F_MIN, F_MAX] and adds `clamped`.
//
// state  | meaning
// IDLE   | no hold active; compare pending request against committed pair
// COMMIT | one cycle: publish pending pair, load hold-off timer
// HOLD   | hold-off running; new requests only overwrite the pending slot
module r820_freq_gate
    import r820_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES      = HOLD_CYCLES_DEF,
    parameter int unsigned BAND_HOLD_CYCLES = BAND_HOLD_CYCLES_DEF,
    parameter int unsigned VHF_THR          = VHF_THR_DEF,
    parameter int unsigned CNT_W            = CNT_W_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rx_freq,
    input  logic        rx_run,
    input  logic        rx_valid,
    output logic [31:0] freq,
    output logic        run,
    output logic        busy,
`ifdef FREQ_CLAMP_EN
    output logic        clamped,
`endif
    output logic [15:0] drop_cnt
);

    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_BAND  = CNT_W'(BAND_HOLD_CYCLES - 1);
    localparam logic [15:0]      THR        = 16'(VHF_THR);

    state_t           state, state_nxt;
    logic [31:0]      pend_f;
    logic             pend_r;
    logic             pend_v;
    logic [31:0]      cap_f;
    logic             same_val;
    logic             long_hold;
    logic             commit;
    logic             consume;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_val;

`ifdef FREQ_CLAMP_EN
    logic clamp_lo, clamp_hi;

    assign clamp_lo = (rx_freq < F_MIN);
    assign clamp_hi = (rx_freq > F_MAX);
    assign cap_f    = clamp_lo ? F_MIN : (clamp_hi ? F_MAX : rx_freq);

    always_ff @(posedge clock) begin
        if (reset) begin
            clamped <= 1'b0;
        end else begin
            clamped <= rx_valid && (clamp_lo || clamp_hi);
        end
    end
`else
    assign cap_f = rx_freq;
`endif

    assign same_val  = ({pend_f, pend_r} == {freq, run});
    assign long_hold = (is_vhf(pend_f, pend_r, THR) != is_vhf(freq, run, THR)) || (pend_r != run);
    assign busy      = (state != IDLE) || pend_v;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        consume   = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = long_hold ? LOAD_BAND : LOAD_SHORT;
        unique case (state)
            IDLE: begin
                if (pend_v) begin
                    if (same_val) begin
                        consume = 1'b1;
                    end else begin
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                consume   = 1'b1;
                tmr_load  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (tmr_done) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A strobe coinciding with consumption of the slot is not a drop; it simply refills it.
    always_ff @(posedge clock) begin
        if (reset) begin
            freq     <= '0;
            run      <= 1'b0;
            pend_f   <= '0;
            pend_r   <= 1'b0;
            pend_v   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (commit) begin
                freq <= pend_f;
                run  <= pend_r;
            end
            if (rx_valid) begin
                pend_f <= cap_f;
                pend_r <= rx_run;
                pend_v <= 1'b1;
                if (pend_v && !consume && (drop_cnt != 16'hFFFF)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (consume) begin
                pend_v <= 1'b0;
            end
        end
    end

    r820_holdoff_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

endmodule

// File: tb/tb_r820_freq_gate.sv
// Directed bench for r820_freq_gate with shortened hold times; FREQ_CLAMP_EN adds the clamp scenario.
module tb_r820_freq_gate;

    localparam int unsigned HOLD  = 20;
    localparam int unsigned BAND  = 60;
    localparam int unsigned LIMIT = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rx_freq = '0;
    logic        rx_run = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] freq;
    logic        run;
    logic        busy;
    logic [15:0] drop_cnt;
`ifdef FREQ_CLAMP_EN
    logic        clamped;
`endif

    int vectors = 0;
    int errors  = 0;

    r820_freq_gate #(
        .HOLD_CYCLES      (HOLD),
        .BAND_HOLD_CYCLES (BAND),
        .VHF_THR          (585),
        .CNT_W            (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_freq  (rx_freq),
        .rx_run   (rx_run),
        .rx_valid (rx_valid),
        .freq     (freq),
        .run      (run),
        .busy     (busy),
`ifdef FREQ_CLAMP_EN
        .clamped  (clamped),
`endif
        .drop_cnt (drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] f, input logic r);
        rx_freq  = f;
        rx_run   = r;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    // Counts samples with busy high, starting at the current one.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b1; rx_freq = 32'd5; rx_run = 1'b1;
        repeat (3) step();
        rx_valid = 1'b0;
        vectors++; if (freq !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d want 0", freq); end
        vectors++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", run); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        reset = 1'b0;
        step();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_first_commit();
        int n;
        send(32'd100_000_000, 1'b1);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy_e0: got %b want 1", busy); end
        step();
        vectors++; if (freq !== 32'd0) begin errors++; $display("FAIL first_freq_e1: got %0d want 0", freq); end
        step();
        vectors++; if (freq !== 32'd100_000_000) begin errors++; $display("FAIL first_freq_e2: got %0d want 100000000", freq); end
        vectors++; if (run !== 1'b1) begin errors++; $display("FAIL first_run_e2: got %b want 1", run); end
        wait_idle(n);
        vectors++; if (n + 2 != BAND + 2) begin errors++; $display("FAIL first_busy_len: got %0d want %0d", n + 2, BAND + 2); end
    endtask

    task automatic test_same_band();
        int n;
        send(32'd433_000_000, 1'b1);
        step(); step();
        vectors++; if (freq !== 32'd433_000_000) begin errors++; $display("FAIL same_first: got %0d want 433000000", freq); end
        repeat (7) step();
        send(32'd434_000_000, 1'b1);
        repeat (HOLD + 3 - 10) step();
        vectors++; if (freq !== 32'd433_000_000) begin errors++; $display("FAIL same_held: got %0d want 433000000", freq); end
        step();
        vectors++; if (freq !== 32'd434_000_000) begin errors++; $display("FAIL same_second: got %0d want 434000000", freq); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL same_drop: got %0d want 0", drop_cnt); end
        wait_idle(n);
        vectors++; if (n != HOLD) begin errors++; $display("FAIL same_hold_len: got %0d want %0d", n, HOLD); end
    endtask

    task automatic test_last_writer();
        int n;
        send(32'd140_000_000, 1'b1);
        step(); step();
        vectors++; if (freq !== 32'd140_000_000) begin errors++; $display("FAIL lw_first: got %0d want 140000000", freq); end
        step(); send(32'd145_000_000, 1'b1);
        step(); send(32'd146_000_000, 1'b1);
        step(); send(32'd147_000_000, 1'b1);
        repeat (HOLD + 3 - 8) step();
        vectors++; if (freq !== 32'd140_000_000) begin errors++; $display("FAIL lw_held: got %0d want 140000000", freq); end
        step();
        vectors++; if (freq !== 32'd147_000_000) begin errors++; $display("FAIL lw_commit: got %0d want 147000000", freq); end
        vectors++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL lw_drop: got %0d want 2", drop_cnt); end
        wait_idle(n);
        vectors++; if (n != HOLD) begin errors++; $display("FAIL lw_hold_len: got %0d want %0d", n, HOLD); end
    endtask

    task automatic test_repeat();
        send(32'd147_000_000, 1'b1);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rep_busy_e0: got %b want 1", busy); end
        step();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rep_busy_e1: got %b want 0", busy); end
        repeat (3) step();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rep_busy_later: got %b want 0", busy); end
        vectors++; if (freq !== 32'd147_000_000) begin errors++; $display("FAIL rep_freq: got %0d want 147000000", freq); end
    endtask

    task automatic test_band();
        logic [31:0] vf [7] = '{32'd30_000_000, 32'd50_000_000, 32'd7_000_000, 32'd38_338_560,
                                32'd38_404_096, 32'd38_404_096, 32'd60_000_000};
        logic        vr [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int          vh [7] = '{BAND, BAND, BAND, HOLD, BAND, BAND, HOLD};
        int n;
        for (int i = 0; i < 7; i++) begin
            send(vf[i], vr[i]);
            step(); step();
            vectors++; if (freq !== vf[i] || run !== vr[i]) begin errors++; $display("FAIL band_commit[%0d]: got %0d/%b want %0d/%b", i, freq, run, vf[i], vr[i]); end
            wait_idle(n);
            vectors++; if (n != vh[i]) begin errors++; $display("FAIL band_hold[%0d]: got %0d want %0d", i, n, vh[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        send(32'd61_000_000, 1'b0);
        step();
        send(32'd62_000_000, 1'b0);
        vectors++; if (freq !== 32'd61_000_000) begin errors++; $display("FAIL b2b_first: got %0d want 61000000", freq); end
        vectors++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL b2b_drop_e2: got %0d want 2", drop_cnt); end
        repeat (HOLD + 1) step();
        vectors++; if (freq !== 32'd61_000_000) begin errors++; $display("FAIL b2b_held: got %0d want 61000000", freq); end
        step();
        vectors++; if (freq !== 32'd62_000_000) begin errors++; $display("FAIL b2b_second: got %0d want 62000000", freq); end
        vectors++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL b2b_drop: got %0d want 2", drop_cnt); end
        wait_idle(n);
        vectors++; if (n != HOLD) begin errors++; $display("FAIL b2b_hold_len: got %0d want %0d", n, HOLD); end
    endtask

    task automatic test_reset_mid_hold();
        send(32'd190_000_000, 1'b1);
        repeat (5) step();
        send(32'd200_000_000, 1'b1);
        step();
        reset = 1'b1;
        step();
        vectors++; if (freq !== 32'd0 || run !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got %0d/%b want 0/0", freq, run); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_drop: got %0d want 0", drop_cnt); end
        reset = 1'b0;
        repeat (BAND + 10) step();
        vectors++; if (freq !== 32'd0) begin errors++; $display("FAIL rst_mid_late: got %0d want 0", freq); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_late_busy: got %b want 0", busy); end
    endtask

`ifdef FREQ_CLAMP_EN
    task automatic test_clamp();
        int n;
        vectors++; if (clamped !== 1'b0) begin errors++; $display("FAIL clamp_idle: got %b want 0", clamped); end
        send(32'd2_000_000_000, 1'b1);
        vectors++; if (clamped !== 1'b1) begin errors++; $display("FAIL clamp_pulse_hi: got %b want 1", clamped); end
        step();
        vectors++; if (clamped !== 1'b0) begin errors++; $display("FAIL clamp_pulse_end: got %b want 0", clamped); end
        step();
        vectors++; if (freq !== 32'd1_766_000_000) begin errors++; $display("FAIL clamp_hi_freq: got %0d want 1766000000", freq); end
        wait_idle(n);
        send(32'd1_000_000, 1'b1);
        vectors++; if (clamped !== 1'b1) begin errors++; $display("FAIL clamp_pulse_lo: got %b want 1", clamped); end
        step(); step();
        vectors++; if (freq !== 32'd24_000_000) begin errors++; $display("FAIL clamp_lo_freq: got %0d want 24000000", freq); end
        wait_idle(n);
    endtask
`endif

    initial begin
        test_reset();
        test_first_commit();
        test_same_band();
        test_last_writer();
        test_repeat();
        test_band();
        test_back_to_back();
        test_reset_mid_hold();
`ifdef FREQ_CLAMP_EN
        test_clamp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
